// File: rtl/line_memory.sv
// Line-granular main memory behind the data cache: accepts one refill or
// write-back at a time and acknowledges it after a fixed number of cycles.
module line_memory #(
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        cnt;
    logic              accept;
    logic              commit;
    logic              wr_lat;
    logic [IDX_W-1:0]  idx_lat;
    logic [LINE_W-1:0] line_lat;
    logic [LINE_W-1:0] rd_line;
    logic [LINE_W-1:0] mem [DEPTH];

    // Only the line index selects storage; offset and high bits wrap away.
    logic addr_unused;
    assign addr_unused = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept)
                cnt <= 8'(LATENCY - 1);
            else if (state == WAIT)
                cnt <= cnt - 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_i) state_next = WAIT;
            WAIT:    if (cnt == 8'd1) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && enable_i;
        commit = (state == WAIT) && (cnt == 8'd1);
        ack_o  = (state == ACK);
        busy_o = (state != IDLE);
    end

    // Request fields are captured once so later input churn cannot leak in.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            wr_lat   <= write_i;
            idx_lat  <= addr_i[5 +: IDX_W];
            line_lat <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && commit && wr_lat)
            mem[idx_lat] <= line_lat;
    end

    // Read data lives only for the ACK cycle, zero at all other times.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rd_line <= '0;
        else if (commit && !wr_lat)
            rd_line <= mem[idx_lat];
        else
            rd_line <= '0;
    end

    assign data_o = rd_line;

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: one instance at LATENCY=10 for the main
// scenarios and a second at LATENCY=2 for sustained-enable timing.
module tb_line_memory;

    localparam int LINE_W = 256;
    localparam int DEPTH  = 512;
    localparam int LAT    = 10;
    localparam int LAT2   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable, write, ack, busy;
    logic [31:0]       addr;
    logic [LINE_W-1:0] din, dout;
    logic              enable2, write2, ack2, busy2;
    logic [31:0]       addr2;
    logic [LINE_W-1:0] din2, dout2;

    int checks = 0;
    int errors = 0;
    logic [LINE_W-1:0] expect_q [$];

    logic [LINE_W-1:0] pat_a5, pat3, pat5, pat2;

    always #5 clk = ~clk;

    line_memory #(.LINE_W(LINE_W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
        .addr_i(addr), .data_i(din), .ack_o(ack), .data_o(dout), .busy_o(busy)
    );

    line_memory #(.LINE_W(LINE_W), .DEPTH(DEPTH), .LATENCY(LAT2)) dut2 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable2), .write_i(write2),
        .addr_i(addr2), .data_i(din2), .ack_o(ack2), .data_o(dout2), .busy_o(busy2)
    );

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one request from a negedge, check every cycle up to and one past
    // the ack, and return at a negedge with the DUT idle again.
    task automatic applyStimulus(input logic wr, input logic [31:0] a,
                                 input logic [LINE_W-1:0] d,
                                 input logic [LINE_W-1:0] rd_expect, input bit churn);
        logic [LINE_W-1:0] exp_line;
        enable = 1'b1;
        write  = wr;
        addr   = a;
        din    = d;
        expect_q.push_back(wr ? '0 : rd_expect);
        @(posedge clk);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            checkOutput("busy_wait", busy, 1);
            checkOutput("ack_timing", ack, (k == LAT - 1) ? 1 : 0);
            if (k == LAT - 1) begin
                exp_line = expect_q.pop_front();
                checkOutput("data_at_ack", dout, exp_line);
                enable = 1'b0;
                write  = 1'b0;
            end else begin
                checkOutput("data_idle", dout, '0);
                if (churn) begin
                    write = 1'b1;
                    addr  = (32'd5 << 5) | 32'($urandom_range(0, 31));
                    din   = {8{$urandom()}};
                end
            end
        end
        @(negedge clk);
        checkOutput("ack_fall", ack, 0);
        checkOutput("busy_fall", busy, 0);
        checkOutput("data_after_ack", dout, '0);
    endtask

    initial begin
        bit seen;
        pat_a5 = {32{8'hA5}};
        pat3   = {8{32'h3333_C0DE}};
        pat5   = {8{32'h5555_BEEF}};
        pat2   = {4{64'h0123_4567_89AB_CDEF}};
        rst = 1'b1;
        enable = 1'b0;  write = 1'b0;  addr = '0;  din = '0;
        enable2 = 1'b0; write2 = 1'b0; addr2 = '0; din2 = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_data", dout, '0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_ack", ack, 0);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_data", dout, '0);
        end

        // Write then read
        applyStimulus(1'b1, 32'h0000_0400, pat_a5, '0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0400, '0, pat_a5, 1'b0);

        // Input churn during WAIT must not affect the read or memory
        applyStimulus(1'b1, 32'd3 << 5, pat3, '0, 1'b0);
        applyStimulus(1'b1, 32'd5 << 5, pat5, '0, 1'b0);
        applyStimulus(1'b0, 32'd3 << 5, '0, pat3, 1'b1);
        applyStimulus(1'b0, 32'd5 << 5, '0, pat5, 1'b0);

        // Address aliasing: DEPTH*32 maps to line 0
        applyStimulus(1'b1, 32'h0000_4000, 256'h1, '0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0000, '0, 256'h1, 1'b0);

        // Reset mid-write drops the write
        applyStimulus(1'b1, 32'd7 << 5, '0, '0, 1'b0);
        enable = 1'b1;
        write  = 1'b1;
        addr   = 32'd7 << 5;
        din    = 256'hFF;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        write  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ack", ack, 0);
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_ack", ack, 0);
        end
        applyStimulus(1'b0, 32'd7 << 5, '0, '0, 1'b0);

        // Sustained enable on the LATENCY=2 instance
        enable2 = 1'b1;
        write2  = 1'b1;
        addr2   = 32'd1 << 5;
        din2    = pat2;
        seen    = 1'b0;
        for (int i = 0; i < 4 * LAT2 && !seen; i++) begin
            @(negedge clk);
            if (ack2) seen = 1'b1;
        end
        checkOutput("l2_write_ack_seen", seen, 1);
        enable2 = 1'b0;
        write2  = 1'b0;
        @(negedge clk);
        enable2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("l2_e0_busy", busy2, 1);
        checkOutput("l2_e0_ack", ack2, 0);
        @(negedge clk);
        checkOutput("l2_e1_ack", ack2, 1);
        checkOutput("l2_e1_data", dout2, pat2);
        @(negedge clk);
        checkOutput("l2_e2_ack", ack2, 0);
        checkOutput("l2_e2_busy", busy2, 0);
        checkOutput("l2_e2_data", dout2, '0);
        @(negedge clk);
        checkOutput("l2_e3_busy", busy2, 1);
        checkOutput("l2_e3_ack", ack2, 0);
        @(negedge clk);
        checkOutput("l2_e4_ack", ack2, 1);
        checkOutput("l2_e4_data", dout2, pat2);
        enable2 = 1'b0;
        @(negedge clk);
        checkOutput("l2_e5_ack", ack2, 0);
        checkOutput("l2_e5_busy", busy2, 0);
        @(negedge clk);
        checkOutput("l2_e6_busy", busy2, 0);
        checkOutput("l2_e6_ack", ack2, 0);

        checkOutput("scoreboard_empty", 256'(expect_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
